// File: rtl/game_state_ctrl_multi.sv
// Game-flow controller: START -> LEVEL_n -> LEVEL_DONE (timed) -> ... -> FINISH,
// with edge-detected start, restart from FINISH and an abort path back to START.
module game_state_ctrl_multi #(
  parameter int NUM_PLAYERS  = 2,
  parameter int NUM_LEVELS   = 4,
  parameter int XPOS_W       = 12,
  parameter int GOAL_X       = 700,
  parameter int TRANS_CYCLES = 40000000,
  localparam int LVL_W = (NUM_LEVELS > 1) ? $clog2(NUM_LEVELS) : 1,
  localparam int CNT_W = $clog2(TRANS_CYCLES + 1)
) (
  input  logic                          clk_40,
  input  logic                          rst_n,
  input  logic                          m_left,
  input  logic                          gpio,
  input  logic                          abort,
  input  logic [NUM_PLAYERS*XPOS_W-1:0] xpos_players,
  output logic [1:0]                    game_state,
  output logic [LVL_W-1:0]              level,
  output logic                          level_start,
  output logic                          game_done
);

  typedef enum logic [1:0] {
    S_START      = 2'd0,
    S_LEVEL      = 2'd1,
    S_LEVEL_DONE = 2'd2,
    S_FINISH     = 2'd3
  } state_t;

  localparam logic [LVL_W-1:0]  LAST_LVL = LVL_W'(NUM_LEVELS - 1);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TRANS_CYCLES - 1);
  localparam logic [XPOS_W-1:0] GOAL_LIM = XPOS_W'(GOAL_X);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             start_lvl;
  logic             start_lvl_q;
  logic             armed;
  logic             start_evt;
  logic             all_goal;

  // armed stays low for the first clock after reset so a button held through
  // reset release cannot masquerade as a fresh press.
  assign start_lvl  = m_left | gpio;
  assign start_evt  = start_lvl & ~start_lvl_q & armed;
  assign game_state = state;

  always_comb begin
    all_goal = 1'b1;
    for (int i = 0; i < NUM_PLAYERS; i++) begin
      if (xpos_players[i*XPOS_W +: XPOS_W] < GOAL_LIM) all_goal = 1'b0;
    end
  end

  always_ff @(posedge clk_40 or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_START;
      level       <= '0;
      level_start <= 1'b0;
      game_done   <= 1'b0;
      cnt         <= '0;
      start_lvl_q <= 1'b0;
      armed       <= 1'b0;
    end else begin
      start_lvl_q <= start_lvl;
      armed       <= 1'b1;
      level_start <= 1'b0;
      game_done   <= 1'b0;
      cnt         <= '0;
      case (state)
        S_START: begin
          if (start_evt) begin
            state       <= S_LEVEL;
            level       <= '0;
            level_start <= 1'b1;
          end
        end
        S_LEVEL: begin
          if (abort) begin
            state <= S_START;
            level <= '0;
          end else if (all_goal) begin
            if (level == LAST_LVL) begin
              state     <= S_FINISH;
              game_done <= 1'b1;
            end else begin
              state <= S_LEVEL_DONE;
            end
          end
        end
        S_LEVEL_DONE: begin
          // Abort wins even in the cycle the dwell counter expires.
          if (abort) begin
            state <= S_START;
            level <= '0;
          end else if (cnt == CNT_LAST) begin
            state       <= S_LEVEL;
            level       <= level + LVL_W'(1);
            level_start <= 1'b1;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        S_FINISH: begin
          if (abort || start_evt) begin
            state <= S_START;
            level <= '0;
          end
        end
        default: begin
          state <= S_START;
          level <= '0;
        end
      endcase
    end
  end

endmodule
